// File: rtl/midi_note_tracker_pkg.sv
// Shared constants for the MIDI note tracker: status nibbles, system-byte limits,
// parser states and helpers that map a status nibble to its data-byte sequence.
package midi_note_tracker_pkg;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_POLY_AT  = 4'hA;
  localparam logic [3:0] NIB_CC       = 4'hB;
  localparam logic [3:0] NIB_PROG     = 4'hC;
  localparam logic [3:0] NIB_CH_AT    = 4'hD;
  localparam logic [3:0] NIB_PITCH    = 4'hE;

  localparam logic [7:0] SYS_COMMON_MIN   = 8'hF0;
  localparam logic [7:0] SYS_RT_MIN       = 8'hF8;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA1 = 3'd1,
    ST_DATA2 = 3'd2,
    ST_SKIP1 = 3'd3,
    ST_SKIP2 = 3'd4,
    ST_DROP  = 3'd5
  } parser_state_t;

  // State entered right after an accepted channel status byte.
  function automatic parser_state_t status_entry_state(input logic [3:0] nib);
    case (nib)
      NIB_NOTE_OFF, NIB_NOTE_ON, NIB_CC: return ST_DATA1;
      NIB_PROG, NIB_CH_AT:               return ST_SKIP1;
      NIB_POLY_AT, NIB_PITCH:            return ST_SKIP2;
      default:                           return ST_DROP;
    endcase
  endfunction

  // State after the first data byte of a running-status message seen in IDLE.
  function automatic parser_state_t running_entry_state(input logic [3:0] nib);
    case (nib)
      NIB_NOTE_OFF, NIB_NOTE_ON, NIB_CC: return ST_DATA2;
      NIB_PROG, NIB_CH_AT:               return ST_IDLE;
      default:                           return ST_SKIP1;
    endcase
  endfunction

endpackage

// File: rtl/midi_note_tracker_note_stack.sv
// Last-note-priority stack of 7-bit keys; index 0 is the oldest entry, the top is
// entry count-1. Keys are kept unique, so a remove matches at most one entry.
module note_stack #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       push_i,
  input  logic       remove_i,
  input  logic       clear_i,
  input  logic [6:0] key_i,
  output logic [6:0] top_o,
  output logic [3:0] count_o,
  output logic       empty_o
);

  localparam logic [3:0] DEPTH_C = 4'(STACK_DEPTH);

  logic [6:0] entry_reg  [STACK_DEPTH];
  logic [6:0] entry_next [STACK_DEPTH];
  logic [6:0] entry_rm   [STACK_DEPTH];
  logic [3:0] count_reg, count_next, count_rm;
  logic [STACK_DEPTH-1:0] match;
  logic [STACK_DEPTH-1:0] passed;
  logic hit;

  // entry_rm is the stack with key_i removed and everything above it shifted down
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_slot
      assign match[gi] = (4'(gi) < count_reg) && (entry_reg[gi] == key_i);
      if (gi == 0) begin : g_first
        assign passed[gi] = match[gi];
      end else begin : g_rest
        assign passed[gi] = passed[gi-1] | match[gi];
      end
      if (gi == STACK_DEPTH - 1) begin : g_top
        assign entry_rm[gi] = passed[gi] ? 7'd0 : entry_reg[gi];
      end else begin : g_low
        assign entry_rm[gi] = passed[gi] ? entry_reg[gi+1] : entry_reg[gi];
      end
    end
  endgenerate

  assign hit      = |match;
  assign count_rm = count_reg - {3'b000, hit};

  always_comb begin
    entry_next = entry_reg;
    count_next = count_reg;
    if (clear_i) begin
      count_next = 4'd0;
    end else if (push_i) begin
      if (count_rm == DEPTH_C) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) entry_next[i] = entry_rm[i+1];
        entry_next[STACK_DEPTH-1] = key_i;
        count_next = DEPTH_C;
      end else begin
        entry_next = entry_rm;
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (4'(i) == count_rm) entry_next[i] = key_i;
        end
        count_next = count_rm + 4'd1;
      end
    end else if (remove_i) begin
      entry_next = entry_rm;
      count_next = count_rm;
    end
  end

  always_comb begin
    top_o = 7'd0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (4'(i) + 4'd1 == count_reg) top_o = entry_reg[i];
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < STACK_DEPTH; i++) entry_reg[i] <= 7'd0;
      count_reg <= 4'd0;
    end else begin
      entry_reg <= entry_next;
      count_reg <= count_next;
    end
  end

  assign count_o = count_reg;
  assign empty_o = (count_reg == 4'd0);

endmodule

// File: rtl/midi_note_tracker.sv
// MIDI byte-stream parser with running status feeding a last-note-priority stack;
// drives oscillator note, gate and a one-cycle phase-reset pulse on each note-on.
module midi_note_tracker
  import midi_note_tracker_pkg::*;
#(
  parameter int         STACK_DEPTH = 4,
  parameter logic [3:0] MIDI_CH     = 4'd0
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] rxData_i,
  input  logic       rxValid_i,
  output logic [7:0] note_o,
  output logic       gate_o,
  output logic       phaseRst_o,
  output logic [3:0] stackCnt_o
);

  parser_state_t state_reg, state_next;
  logic       rs_valid_reg, rs_valid_next;
  logic [3:0] rs_nib_reg, rs_nib_next;
  logic [6:0] key_reg, key_next;
  logic       phase_rst_reg, phase_rst_next;
  logic [6:0] note_hold_reg;
  logic       push, remove, clear;
  logic [6:0] stack_top;
  logic [3:0] stack_cnt;
  logic       stack_empty;

  always_comb begin
    state_next     = state_reg;
    rs_valid_next  = rs_valid_reg;
    rs_nib_next    = rs_nib_reg;
    key_next       = key_reg;
    phase_rst_next = 1'b0;
    push           = 1'b0;
    remove         = 1'b0;
    clear          = 1'b0;
    // Real-time bytes fall through untouched
    if (rxValid_i && (rxData_i < SYS_RT_MIN)) begin
      if (rxData_i[7]) begin
        if (rxData_i >= SYS_COMMON_MIN) begin
          rs_valid_next = 1'b0;
          state_next    = ST_DROP;
        end else if (rxData_i[3:0] == MIDI_CH) begin
          rs_valid_next = 1'b1;
          rs_nib_next   = rxData_i[7:4];
          state_next    = status_entry_state(rxData_i[7:4]);
        end else begin
          rs_valid_next = 1'b0;
          state_next    = ST_DROP;
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (rs_valid_reg) begin
              key_next   = rxData_i[6:0];
              state_next = running_entry_state(rs_nib_reg);
            end
          end
          ST_DATA1: begin
            key_next   = rxData_i[6:0];
            state_next = ST_DATA2;
          end
          ST_DATA2: begin
            state_next = ST_IDLE;
            case (rs_nib_reg)
              NIB_NOTE_ON: begin
                if (rxData_i[6:0] != 7'd0) begin
                  push           = 1'b1;
                  phase_rst_next = 1'b1;
                end else begin
                  remove = 1'b1;
                end
              end
              NIB_NOTE_OFF: remove = 1'b1;
              NIB_CC:       clear  = (key_reg == CC_ALL_NOTES_OFF);
              default:      ;
            endcase
          end
          ST_SKIP2: state_next = ST_SKIP1;
          ST_SKIP1: state_next = ST_IDLE;
          default:  state_next = state_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg     <= ST_IDLE;
      rs_valid_reg  <= 1'b0;
      rs_nib_reg    <= 4'd0;
      key_reg       <= 7'd0;
      phase_rst_reg <= 1'b0;
      note_hold_reg <= 7'd0;
    end else begin
      state_reg     <= state_next;
      rs_valid_reg  <= rs_valid_next;
      rs_nib_reg    <= rs_nib_next;
      key_reg       <= key_next;
      phase_rst_reg <= phase_rst_next;
      note_hold_reg <= note_o[6:0];
    end
  end

  note_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (push),
    .remove_i(remove),
    .clear_i (clear),
    .key_i   (key_reg),
    .top_o   (stack_top),
    .count_o (stack_cnt),
    .empty_o (stack_empty)
  );

  // An empty stack keeps presenting the last sounded note
  assign note_o     = {1'b0, stack_empty ? note_hold_reg : stack_top};
  assign gate_o     = ~stack_empty;
  assign phaseRst_o = phase_rst_reg;
  assign stackCnt_o = stack_cnt;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Directed and randomized byte streams checked against a message-level model
// (running-status byte plus collected data bytes, held keys in a queue).
module tb_midi_note_tracker;

  localparam int         DEPTH = 4;
  localparam logic [3:0] CH    = 4'd0;

  logic       clk_i = 1'b0;
  logic       nrst_i = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] note_o;
  logic       gate_o;
  logic       phase_rst;
  logic [3:0] stack_cnt;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;

  int model_q[$];
  int model_data[$];
  int model_rs = -1;
  int model_last = 0;
  bit model_pulse = 0;

  midi_note_tracker #(
    .STACK_DEPTH(DEPTH),
    .MIDI_CH    (CH)
  ) dut (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .rxData_i  (rx_data),
    .rxValid_i (rx_valid),
    .note_o    (note_o),
    .gate_o    (gate_o),
    .phaseRst_o(phase_rst),
    .stackCnt_o(stack_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_data.delete();
    model_rs    = -1;
    model_last  = 0;
    model_pulse = 0;
  endtask

  task automatic model_remove(input int key);
    for (int i = 0; i < model_q.size(); i++) begin
      if (model_q[i] == key) begin
        model_q.delete(i);
        break;
      end
    end
  endtask

  task automatic model_byte(input int b);
    int nib;
    int need;
    model_pulse = 0;
    if (b >= 'hF8) begin
      // real-time: invisible
    end else if (b >= 'hF0) begin
      model_rs = -1;
      model_data.delete();
    end else if (b >= 'h80) begin
      model_data.delete();
      model_rs = ((b & 15) == int'(CH)) ? b : -1;
    end else if (model_rs >= 0) begin
      model_data.push_back(b);
      nib  = model_rs >> 4;
      need = (nib == 12 || nib == 13) ? 1 : 2;
      if (model_data.size() == need) begin
        if (nib == 9 && model_data[1] != 0) begin
          model_remove(model_data[0]);
          if (model_q.size() == DEPTH) void'(model_q.pop_front());
          model_q.push_back(model_data[0]);
          model_pulse = 1;
        end else if (nib == 9 || nib == 8) begin
          model_remove(model_data[0]);
        end else if (nib == 11 && model_data[0] == 'h7B) begin
          model_q.delete();
        end
        model_data.delete();
      end
    end
    if (model_q.size() > 0) model_last = model_q[$];
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, " note"},  note_o,          8'(model_last));
    check({ctx, " gate"},  8'(gate_o),      8'(model_q.size() > 0));
    check({ctx, " pulse"}, 8'(phase_rst),   8'(model_pulse));
    check({ctx, " count"}, 8'(stack_cnt),   8'(model_q.size()));
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid = 1'b0;
    model_byte(int'(b));
    if (phase_rst) pulse_count++;
    $display("byte %02h -> note %0d gate %0d pulse %0d count %0d", b, note_o, gate_o, phase_rst, stack_cnt);
    check_outputs($sformatf("byte %02h", b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      model_pulse = 0;
      check_outputs("idle");
    end
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset");
    nrst_i = 1'b1;
    idle(1);

    // Basic note-on
    send(8'h90); send(8'h3C); send(8'h64);
    check("t1 note", note_o, 8'd60);
    check("t1 pulse", 8'(phase_rst), 8'd1);
    idle(1);
    check("t1 pulse drop", 8'(phase_rst), 8'd0);
    send(8'h80); send(8'h3C); send(8'h00);

    // Running status and legato fall-back
    pulse_count = 0;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h40); send(8'h64);
    check("rs note", note_o, 8'd64);
    send(8'h80); send(8'h40); send(8'h00);
    check("legato note", note_o, 8'd60);
    check("legato gate", 8'(gate_o), 8'd1);
    check("legato pulses", 8'(pulse_count), 8'd2);
    send(8'hB0); send(8'h7B); send(8'h00);

    // Real-time byte mid-message
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'hF8); send(8'h3C); send(8'h00);
    check("rt gate", 8'(gate_o), 8'd0);
    check("rt note", note_o, 8'd60);

    // Overflow drops the oldest key
    send(8'h90);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h64); send(8'h40); send(8'h64);
    send(8'h41); send(8'h64); send(8'h43); send(8'h64);
    check("full count", 8'(stack_cnt), 8'(DEPTH));
    send(8'h80);
    send(8'h43); send(8'h00); send(8'h41); send(8'h00); send(8'h40); send(8'h00);
    send(8'h3E); send(8'h00);
    check("ovf gate", 8'(gate_o), 8'd0);
    check("ovf note", note_o, 8'd62);

    // Foreign channel, then all-notes-off
    send(8'h91); send(8'h3C); send(8'h64);
    check("ch2 gate", 8'(gate_o), 8'd0);
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h64); send(8'h40); send(8'h64);
    send(8'hB0); send(8'h7B); send(8'h00);
    check("anf count", 8'(stack_cnt), 8'd0);
    check("anf pulse", 8'(phase_rst), 8'd0);

    // Reset mid-message
    send(8'h90); send(8'h3C);
    #2;
    nrst_i = 1'b0;
    model_reset();
    #1;
    check_outputs("async reset");
    @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    send(8'h64);
    check("post-reset note", note_o, 8'd0);
    check("post-reset gate", 8'(gate_o), 8'd0);

    // Randomized stream
    for (int n = 0; n < 800; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 30)      b = 8'(8'h3C + $urandom_range(0, 7));
      else if (r < 45) b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 127));
      else if (r < 55) b = 8'h90;
      else if (r < 62) b = 8'h80;
      else if (r < 66) b = {4'h9, 4'($urandom_range(1, 15))};
      else if (r < 70) b = 8'hB0;
      else if (r < 73) b = 8'h7B;
      else if (r < 76) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 79) b = 8'($urandom_range(8'hF0, 8'hF7));
      else if (r < 83) b = ($urandom_range(0, 1) != 0) ? 8'hC0 : 8'hD0;
      else if (r < 87) b = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'hE0;
      else if (r < 92) b = 8'($urandom_range(0, 127));
      else             b = 8'($urandom_range(0, 255));
      send(b);
      if ($urandom_range(0, 9) == 0) idle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
